// File: rtl/color_pkg.sv
`default_nettype none
// ============================================================================
// Package : color_pkg
// Shared state encoding, constants and helpers for target-colour learning.
// Rev     : 1.0  initial release
// ============================================================================
package color_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_EVAL   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_FAIL   = 3'd5
  } learn_state_e;

  localparam logic [23:0] HSV_NONE = 24'hFFFFFF;
  localparam int          NUM_CH   = 3;

  // Half-open span test: base <= pos < base + side.
  function automatic logic in_span(input logic [31:0] pos,
                                   input logic [31:0] base,
                                   input logic [31:0] side);
    return (pos >= base) && (pos < (base + side));
  endfunction

  // Plain unsigned distance; hue is deliberately not treated as circular.
  function automatic logic [7:0] abs_diff8(input logic [7:0] a,
                                           input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage
`default_nettype wire

// File: rtl/color_learn_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce
// Two-flop synchroniser, stability counter and one-cycle rising-edge pulse.
// Rev    : 1.0  initial release
// ============================================================================
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned      CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level, so any bounce restarts the qualification window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
        press_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/color_learn_ctrl.sv
`default_nettype none
// ============================================================================
// Module : color_learn_ctrl
// Learns a target HSV colour from the centre window over agreeing frames.
// Rev    : 1.0  initial release
// ============================================================================
module color_learn_ctrl
  import color_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 250000,
  parameter int unsigned WIN_H0       = 144,
  parameter int unsigned WIN_V0       = 104,
  parameter int unsigned WIN_LOG2     = 5,
  parameter int unsigned RESULT_LINE  = 239,
  parameter int unsigned N_STABLE     = 3,
  parameter int unsigned TOL          = 8,
  parameter int unsigned MAX_TRIES    = 8
) (
  input  logic        PClk,
  input  logic        rst_n,
  input  logic        btn_ColorExtract,
  input  logic        sw_ColorClear,
  input  logic [11:0] VtcHCnt,
  input  logic [10:0] VtcVCnt,
  input  logic [23:0] HSV24,
  output logic [23:0] HSV_detect,
  output logic        learn_busy,
  output logic        learn_valid,
  output logic        learn_fail,
  output logic        win_active
);

  localparam int unsigned SUM_W     = 8 + 2 * WIN_LOG2;
  localparam int unsigned AVG_SHIFT = 2 * WIN_LOG2;
  localparam int unsigned STB_W     = $clog2(N_STABLE + 1);
  localparam int unsigned TRY_W     = $clog2(MAX_TRIES + 1);
  localparam logic [31:0] WIN_SIDE  = 32'(1) << WIN_LOG2;

  learn_state_e state_q, state_d;

  logic [NUM_CH-1:0][SUM_W-1:0] sum_q, sum_d;
  logic [NUM_CH-1:0][7:0]       ref_q, ref_d;
  logic [NUM_CH-1:0][7:0]       avg;
  logic [STB_W-1:0]             stable_q, stable_d;
  logic [TRY_W-1:0]             tries_q, tries_d;
  logic [23:0]                  hsv_q, hsv_d;
  logic                         valid_q, valid_d;
  logic [1:0]                   clr_sync_q;

  logic                         press;
  logic                         press_ok;
  logic                         clear;
  logic                         frame_start;
  logic                         result_stb;
  logic                         win_hit;
  logic                         eval_within;
  logic [NUM_CH-1:0][7:0]       eval_ref;
  logic [STB_W-1:0]             eval_stable;
  logic [TRY_W-1:0]             eval_tries;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk_i   (PClk),
    .rst_ni  (rst_n),
    .btn_i   (btn_ColorExtract),
    .press_o (press)
  );

  always_ff @(posedge PClk or negedge rst_n) begin
    if (!rst_n) begin
      clr_sync_q <= '0;
    end else begin
      clr_sync_q <= {clr_sync_q[0], sw_ColorClear};
    end
  end

  assign clear       = clr_sync_q[1];
  assign press_ok    = press && !clear;
  assign frame_start = (VtcVCnt == 11'd1) && (VtcHCnt == 12'd1);
  assign result_stb  = (VtcVCnt == 11'(RESULT_LINE)) && (VtcHCnt == 12'd0);
  assign win_hit     = in_span(32'(VtcHCnt), 32'(WIN_H0), WIN_SIDE) &&
                       in_span(32'(VtcVCnt), 32'(WIN_V0), WIN_SIDE);
  assign win_active  = win_hit;

  // Frame evaluation: window sums never overflow, so a shift is the mean.
  always_comb begin
    eval_within = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      avg[i] = 8'(sum_q[i] >> AVG_SHIFT);
      if (abs_diff8(avg[i], ref_q[i]) > 8'(TOL)) begin
        eval_within = 1'b0;
      end
    end

    eval_ref    = ref_q;
    eval_stable = stable_q;
    eval_tries  = tries_q;
    if (stable_q == '0) begin
      eval_ref    = avg;
      eval_stable = STB_W'(1);
    end else if (eval_within) begin
      eval_stable = stable_q + STB_W'(1);
    end else begin
      eval_ref    = avg;
      eval_stable = STB_W'(1);
      eval_tries  = tries_q + TRY_W'(1);
    end
  end

  always_ff @(posedge PClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (press_ok) state_d = ST_ARM;
      ST_ARM:    if (frame_start) state_d = ST_ACCUM;
      ST_ACCUM:  if (result_stb) state_d = ST_EVAL;
      ST_EVAL: begin
        if (eval_stable == STB_W'(N_STABLE)) begin
          state_d = ST_COMMIT;
        end else if (eval_tries == TRY_W'(MAX_TRIES)) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_FAIL:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    learn_busy  = (state_q != ST_IDLE);
    learn_fail  = (state_q == ST_FAIL);
    learn_valid = valid_q;
    HSV_detect  = hsv_q;
  end

  // Clear is applied last so it overrides a commit landing in the same cycle.
  always_comb begin
    sum_d    = sum_q;
    ref_d    = ref_q;
    stable_d = stable_q;
    tries_d  = tries_q;
    hsv_d    = hsv_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (press_ok) begin
          stable_d = '0;
          tries_d  = '0;
        end
      end
      ST_ARM: begin
        if (frame_start) begin
          sum_d = '0;
        end
      end
      ST_ACCUM: begin
        if (win_hit) begin
          for (int i = 0; i < NUM_CH; i++) begin
            sum_d[i] = sum_q[i] + SUM_W'(HSV24[8*i +: 8]);
          end
        end
      end
      ST_EVAL: begin
        ref_d    = eval_ref;
        stable_d = eval_stable;
        tries_d  = eval_tries;
      end
      ST_COMMIT: begin
        hsv_d   = ref_q;
        valid_d = 1'b1;
      end
      default: ;
    endcase
    if (clear) begin
      hsv_d   = HSV_NONE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge PClk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      ref_q    <= '0;
      stable_q <= '0;
      tries_q  <= '0;
      hsv_q    <= HSV_NONE;
      valid_q  <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      ref_q    <= ref_d;
      stable_q <= stable_d;
      tries_q  <= tries_d;
      hsv_q    <= hsv_d;
      valid_q  <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_color_learn_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_color_learn_ctrl
// Directed self-checking bench for color_learn_ctrl on a compressed VTC sweep.
// Rev    : 1.0  initial release
// ============================================================================
module tb_color_learn_ctrl;

  logic        PClk  = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn   = 1'b0;
  logic        sw    = 1'b0;
  logic [11:0] hcnt  = '0;
  logic [10:0] vcnt  = '0;
  logic [23:0] hsv   = 24'hFFFFFF;

  logic [23:0] HSV_detect;
  logic        learn_busy;
  logic        learn_valid;
  logic        learn_fail;
  logic        win_active;

  int   n_checks   = 0;
  int   n_errors   = 0;
  int   fail_seen  = 0;
  int   busy_rises = 0;
  logic busy_d1    = 1'b0;

  logic [7:0] px_h = '0;
  logic [7:0] px_s = '0;
  logic [7:0] px_v = '0;
  bit         px_ramp = 1'b0;

  always #5 PClk = ~PClk;

  color_learn_ctrl #(
    .DEBOUNCE_CYC (4)
  ) dut (
    .PClk             (PClk),
    .rst_n            (rst_n),
    .btn_ColorExtract (btn),
    .sw_ColorClear    (sw),
    .VtcHCnt          (hcnt),
    .VtcVCnt          (vcnt),
    .HSV24            (hsv),
    .HSV_detect       (HSV_detect),
    .learn_busy       (learn_busy),
    .learn_valid      (learn_valid),
    .learn_fail       (learn_fail),
    .win_active       (win_active)
  );

  always @(negedge PClk) begin
    busy_d1 <= learn_busy;
    if (learn_fail) fail_seen <= fail_seen + 1;
    if (learn_busy && !busy_d1) busy_rises <= busy_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int v, input int h);
    int x;
    int y;
    @(negedge PClk);
    vcnt = 11'(v);
    hcnt = 12'(h);
    x = h - 144;
    y = v - 104;
    if (x >= 0 && x < 32 && y >= 0 && y < 32)
      hsv = {px_h, px_s, px_ramp ? px_v + 8'((x + y) % 32) : px_v};
    else
      hsv = 24'hFFFFFF;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0);
  endtask

  task automatic press_btn();
    btn = 1'b1;
    idle(10);
    btn = 1'b0;
    idle(10);
  endtask

  // Only the lines and columns that matter are visited: frame start,
  // the window plus margin, and the result line.
  task automatic run_frame(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v,
                           input bit ramp, input bit clr_in_commit);
    px_h = h;
    px_s = s;
    px_v = v;
    px_ramp = ramp;
    drive(0, 0);
    drive(1, 0);
    drive(1, 1);
    drive(1, 2);
    for (int y = 104; y < 136; y++)
      for (int x = 142; x < 178; x++)
        drive(y, x);
    drive(239, 0);
    if (clr_in_commit) sw = 1'b1;
    drive(239, 1);
    if (clr_in_commit) sw = 1'b0;
    drive(240, 0);
    drive(240, 1);
    drive(240, 2);
  endtask

  initial begin
    int fb;
    int bb;
    int fail_frame;

    idle(3);
    check("rst_hsv", HSV_detect, 24'hFFFFFF);
    check("rst_busy", learn_busy, 0);
    check("rst_valid", learn_valid, 0);
    check("rst_fail", learn_fail, 0);
    rst_n = 1'b1;
    idle(3);

    drive(104, 144); #1 check("win_topleft", win_active, 1);
    drive(104, 143); #1 check("win_left_out", win_active, 0);
    drive(135, 175); #1 check("win_botright", win_active, 1);
    drive(136, 175); #1 check("win_below", win_active, 0);
    drive(104, 176); #1 check("win_right_out", win_active, 0);

    // Constant colour learns after three agreeing frames.
    press_btn();
    check("A_busy_armed", learn_busy, 1);
    run_frame(8'd40, 8'd200, 8'd150, 1'b0, 1'b0);
    run_frame(8'd40, 8'd200, 8'd150, 1'b0, 1'b0);
    check("A_busy_f2", learn_busy, 1);
    check("A_valid_f2", learn_valid, 0);
    check("A_hsv_f2", HSV_detect, 24'hFFFFFF);
    run_frame(8'd40, 8'd200, 8'd150, 1'b0, 1'b0);
    check("A_hsv", HSV_detect, 24'h28C896);
    check("A_valid", learn_valid, 1);
    check("A_busy_done", learn_busy, 0);

    // Alternating V never agrees: fail on the ninth frame, old colour kept.
    fb = fail_seen;
    fail_frame = 0;
    press_btn();
    for (int i = 1; i <= 12; i++) begin
      run_frame(8'd40, 8'd200, (i % 2 != 0) ? 8'd150 : 8'd170, 1'b0, 1'b0);
      if (fail_frame == 0 && fail_seen != fb) fail_frame = i;
    end
    check("B_fail_frame", fail_frame, 9);
    check("B_fail_pulses", fail_seen - fb, 1);
    check("B_hsv_kept", HSV_detect, 24'h28C896);
    check("B_valid_kept", learn_valid, 1);
    check("B_busy", learn_busy, 0);

    // Clear level wipes the colour and blocks presses.
    sw = 1'b1;
    idle(4);
    check("C_hsv", HSV_detect, 24'hFFFFFF);
    check("C_valid", learn_valid, 0);
    press_btn();
    check("C_press_blocked", learn_busy, 0);
    sw = 1'b0;
    idle(4);

    // Two-cycle glitch must not arm.
    bb = busy_rises;
    btn = 1'b1;
    idle(2);
    btn = 1'b0;
    idle(12);
    check("D_glitch_busy", learn_busy, 0);
    check("D_glitch_rises", busy_rises - bb, 0);

    // Ramp pattern: V sum 169472 >> 10 = 165 (truncated); second press ignored.
    bb = busy_rises;
    press_btn();
    run_frame(8'd40, 8'd200, 8'd150, 1'b1, 1'b0);
    press_btn();
    run_frame(8'd40, 8'd200, 8'd150, 1'b1, 1'b0);
    run_frame(8'd40, 8'd200, 8'd150, 1'b1, 1'b0);
    check("E_hsv", HSV_detect, 24'h28C8A5);
    check("E_valid", learn_valid, 1);
    run_frame(8'd40, 8'd200, 8'd150, 1'b1, 1'b0);
    run_frame(8'd40, 8'd200, 8'd150, 1'b1, 1'b0);
    check("E_busy", learn_busy, 0);
    check("E_single_arm", busy_rises - bb, 1);

    // Asynchronous reset in the middle of accumulation.
    press_btn();
    drive(0, 0);
    drive(1, 1);
    for (int x = 144; x < 160; x++) drive(104, x);
    #2 rst_n = 1'b0;
    #1;
    check("G_rst_hsv", HSV_detect, 24'hFFFFFF);
    check("G_rst_valid", learn_valid, 0);
    check("G_rst_busy", learn_busy, 0);
    check("G_rst_fail", learn_fail, 0);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    press_btn();
    run_frame(8'd40, 8'd200, 8'd150, 1'b0, 1'b0);
    run_frame(8'd40, 8'd200, 8'd150, 1'b0, 1'b0);
    run_frame(8'd40, 8'd200, 8'd150, 1'b0, 1'b0);
    check("G_relearn_hsv", HSV_detect, 24'h28C896);
    check("G_relearn_valid", learn_valid, 1);

    // One-cycle clear landing exactly on the COMMIT cycle.
    sw = 1'b1;
    idle(4);
    sw = 1'b0;
    idle(4);
    press_btn();
    run_frame(8'd40, 8'd200, 8'd150, 1'b0, 1'b0);
    run_frame(8'd40, 8'd200, 8'd150, 1'b0, 1'b0);
    run_frame(8'd40, 8'd200, 8'd150, 1'b0, 1'b1);
    check("F_hsv", HSV_detect, 24'hFFFFFF);
    check("F_valid", learn_valid, 0);
    check("F_busy", learn_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
